// File: rtl/io_port_hub.sv
// I/O port hub: CPU output FIFO, single-word input latch with overrun flag, and
// an optional edge-triggered interrupt controller built only when IO_HUB_IRQ_EN is defined.
module io_port_hub #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter int N_IRQ     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_out_wr,
    input  logic [DATA_W-1:0]        cpu_out_data,
    output logic                     cpu_out_full,
    output logic [DATA_W-1:0]        out_port_data,
    output logic                     out_port_valid,
    input  logic                     out_port_ready,
    input  logic [DATA_W-1:0]        in_port_data,
    input  logic                     in_port_strobe,
    input  logic                     cpu_in_rd,
    output logic [DATA_W-1:0]        cpu_in_data,
    output logic                     cpu_in_valid,
    output logic                     in_overrun,
    input  logic [N_IRQ-1:0]         irq_req,
    input  logic [N_IRQ-1:0]         irq_mask,
    output logic                     irq_out,
    output logic [$clog2(N_IRQ)-1:0] irq_id,
    input  logic                     irq_ack
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int IW = $clog2(N_IRQ);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(OUT_DEPTH);

    logic [DATA_W-1:0] r_mem [OUT_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Full/empty come from the registered count only, so a pop never makes room for a same-cycle push.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = cpu_out_wr && !w_full;
    assign w_pop   = !w_empty && out_port_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= cpu_out_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign cpu_out_full   = w_full;
    assign out_port_valid = !w_empty;
    // Stale storage is hidden while empty so the port reads 0 after reset.
    assign out_port_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    logic [DATA_W-1:0] r_in_data;
    logic              r_in_valid;
    logic              r_overrun;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_data  <= '0;
            r_in_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (in_port_strobe && (!r_in_valid || cpu_in_rd)) begin
                r_in_data  <= in_port_data;
                r_in_valid <= 1'b1;
            end else if (cpu_in_rd && r_in_valid) begin
                r_in_valid <= 1'b0;
            end
            if (in_port_strobe && r_in_valid && !cpu_in_rd) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign cpu_in_data  = r_in_data;
    assign cpu_in_valid = r_in_valid;
    assign in_overrun   = r_overrun;

`ifdef IO_HUB_IRQ_EN
    logic [N_IRQ-1:0] r_irq_prev;
    logic [N_IRQ-1:0] r_pending;
    logic             r_irq_out;
    logic [IW-1:0]    r_irq_id;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_active;
    logic [IW-1:0]    w_win_id;

    assign w_rise = irq_req & ~r_irq_prev;

    always_comb begin
        w_clr = '0;
        if (irq_ack && r_irq_out) begin
            w_clr[r_irq_id] = 1'b1;
        end
    end

    // The channel being acknowledged is left out of arbitration this cycle so it is not re-signalled stale.
    assign w_active = r_pending & ~w_clr & irq_mask;

    always_comb begin
        w_win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_win_id = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_irq_out  <= 1'b0;
            r_irq_id   <= '0;
        end else begin
            r_irq_prev <= irq_req;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            r_irq_out  <= |w_active;
            r_irq_id   <= w_win_id;
        end
    end

    assign irq_out = r_irq_out;
    assign irq_id  = r_irq_id;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{irq_req, irq_mask, irq_ack};
    assign irq_out = 1'b0;
    assign irq_id  = '0;
`endif

endmodule
